mem_access_stage: RTL
=====================

# mem_access_stage

Pipeline MEM stage: consumes the EX-stage results (ALU result, destination register, store data, memory control, branch flags) and performs the data-memory access over a req/ack handshake. It stalls the upstream pipeline while an access is outstanding. It produces the MEM/WB pipeline registers and resolves conditional branches. It sits between the execution stage and register-file writeback.

## Interface
- ADDR_W, 10, data-memory word-address width (word-addressed; byte address bits [ADDR_W+1:2] used)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ALUout  in  32  EX result; byte address for lw/sw, write data otherwise
- XM_RD  in  5  destination register; 0 = no writeback
- XM_MemToReg  in  1  load
- XM_MemWrite  in  1  store
- XM_RT  in  32  store data
- DX_PC  in  32  PC+4 of branch instruction
- DX_offset  in  32  sign-extended word offset
- zero, sign  in  1  EX compare flags (A==B, A>B)
- DX_beq, DX_bne, DX_bgt  in  1  branch type
- stall  out  1  hold all upstream stages this cycle
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word address
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, valid with dmem_ack
- dmem_ack  in  1  access complete
- MW_data  out  32  writeback value
- MW_RD  out  5  writeback register, 0 = bubble
- MW_MemToReg  out  1  MW_data came from memory
- branch_taken  out  1  registered branch decision
- branch_target  out  32  registered target
- misalign  out  1  sticky misaligned-access flag (macro only)

## Operation
- access = XM_MemToReg | XM_MemWrite. A load takes precedence if both are set; dmem_we = 0 in that case.
- FSM states: IDLE, BUSY.
  - IDLE, !access: 1-cycle pass-through.
    - MW_data <= ALUout, MW_RD <= XM_RD, MW_MemToReg <= 0.
  - IDLE, access: go to BUSY.
    - Register dmem_req <= 1, dmem_we <= XM_MemWrite & !XM_MemToReg.
    - Register dmem_addr <= ALUout[ADDR_W+1:2], dmem_wdata <= XM_RT.
    - MW_RD <= 0 (bubble).
  - BUSY, !dmem_ack: hold all dmem_* outputs; MW_RD <= 0.
  - BUSY, dmem_ack: go to IDLE; dmem_req <= 0, dmem_we <= 0.
    - Load: MW_data <= dmem_rdata, MW_RD <= XM_RD, MW_MemToReg <= 1.
    - Store: MW_RD <= 0.
- stall = (IDLE & access) | (BUSY & !dmem_ack), combinational. Upstream holds all XM_*/DX_* inputs stable while stall = 1.
- Branch resolution, on every edge with stall = 0:
  - branch_taken <= (DX_beq & zero) | (DX_bne & !zero) | (DX_bgt & sign).
  - branch_target <= DX_PC + (DX_offset << 2), 32-bit wrap-around, carry discarded.
  - On edges with stall = 1: branch_taken <= 0, branch_target holds.
- dmem_ack while IDLE is ignored.

## Timing
- Reset values: all outputs 0; state IDLE. Asserting rst mid-access drops dmem_req immediately (asynchronous) and abandons the access.
- Non-memory op: MW_* valid 1 edge after it is presented.
- Memory op:
  - dmem_req rises 1 edge after it is presented.
  - MW_* is written on the edge that samples dmem_ack.
  - Minimum latency 2 edges (ack in the first req cycle); latency is 2+N for N wait cycles.
- stall deasserts in the cycle dmem_ack = 1, so the next instruction enters on the same edge that completes the access.
- Back-to-back accesses: IDLE lasts exactly one cycle between them; dmem_req drops for exactly one cycle.

## Configuration
- MEM_MISALIGN_CHECK_EN defined:
  - An access with ALUout[1:0] != 0 in IDLE does not enter BUSY, asserts no dmem_req, and raises no stall.
  - MW_RD <= 0.
  - misalign <= 1 and stays set until rst.
- Not defined: ALUout[1:0] is ignored (word truncation) and misalign is tied to 0.

## Test plan
- Reset mid-BUSY: rst pulse while dmem_req = 1 → dmem_req = 0 immediately, state IDLE, MW_RD = 0, stall = 0.
- ALU pass-through: ALUout = 0x0000_002A, XM_RD = 5, no access → next edge MW_data = 0x2A, MW_RD = 5, MW_MemToReg = 0, stall never high.
- Load with 2 wait cycles: ALUout = 0x10, XM_MemToReg = 1, XM_RD = 8; ack on the 3rd req cycle with rdata = 0xDEADBEEF.
  - dmem_addr = 4, stall high for 3 cycles.
  - MW_data = 0xDEADBEEF, MW_RD = 8, MW_MemToReg = 1.
- Store, zero-wait ack: ALUout = 0x20, XM_RT = 0x1234, XM_MemWrite = 1.
  - dmem_we = 1, dmem_addr = 8, dmem_wdata = 0x1234.
  - MW_RD = 0; total 2 edges.
- Branches with DX_PC = 0x100, DX_offset = 0xFFFF_FFFE:
  - beq & zero → branch_taken = 1, branch_target = 0xF8.
  - bne & zero → branch_taken = 0.
  - bgt & sign → branch_taken = 1.
- Misalign, macro on: lw at ALUout = 0x13 → no dmem_req, misalign = 1 and sticky.
- Misalign, macro off: lw at ALUout = 0x13 → dmem_addr = 4, misalign = 0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory req/ack access, MEM/WB registers, branch resolution.
// Optional feature macro MEM_MISALIGN_CHECK_EN: reject misaligned accesses and set sticky misalign.
module mem_access_stage #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ALUout,
  input  logic [4:0]        XM_RD,
  input  logic              XM_MemToReg,
  input  logic              XM_MemWrite,
  input  logic [31:0]       XM_RT,
  input  logic [31:0]       DX_PC,
  input  logic [31:0]       DX_offset,
  input  logic              zero,
  input  logic              sign,
  input  logic              DX_beq,
  input  logic              DX_bne,
  input  logic              DX_bgt,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic [31:0]       MW_data,
  output logic [4:0]        MW_RD,
  output logic              MW_MemToReg,
  output logic              branch_taken,
  output logic [31:0]       branch_target,
  output logic              misalign
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      r_state;
  logic        w_access;
  logic        w_misaligned;
  logic        w_taken;
  logic [31:0] w_target;

  assign w_access = XM_MemToReg | XM_MemWrite;

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misaligned = (ALUout[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  // A misaligned access is dropped in IDLE, so it never holds the pipeline.
  assign stall = ((r_state == IDLE) & w_access & ~w_misaligned) |
                 ((r_state == BUSY) & ~dmem_ack);

  assign w_taken  = (DX_beq & zero) | (DX_bne & ~zero) | (DX_bgt & sign);
  assign w_target = DX_PC + {DX_offset[29:0], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      MW_data       <= '0;
      MW_RD         <= '0;
      MW_MemToReg   <= 1'b0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      misalign      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_access) begin
            MW_data     <= ALUout;
            MW_RD       <= XM_RD;
            MW_MemToReg <= 1'b0;
          end else if (w_misaligned) begin
            MW_RD    <= '0;
            misalign <= 1'b1;
          end else begin
            r_state    <= BUSY;
            dmem_req   <= 1'b1;
            dmem_we    <= XM_MemWrite & ~XM_MemToReg;
            dmem_addr  <= ALUout[ADDR_W+1:2];
            dmem_wdata <= XM_RT;
            MW_RD      <= '0;
          end
        end
        BUSY: begin
          if (!dmem_ack) begin
            MW_RD <= '0;
          end else begin
            r_state  <= IDLE;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (XM_MemToReg) begin
              MW_data     <= dmem_rdata;
              MW_RD       <= XM_RD;
              MW_MemToReg <= 1'b1;
            end else begin
              MW_RD <= '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      // Branch decision is squashed while the stage is stalled; target holds.
      if (!stall) begin
        branch_taken  <= w_taken;
        branch_target <= w_target;
      end else begin
        branch_taken  <= 1'b0;
      end
    end
  end

endmodule
